// File: rtl/encoder4_pend.sv
// encoder4_pend: registered priority encoder with a pending-request register.
// Request lines are merged into pend every cycle; each pending line is
// returned as a binary code over a valid/ready handshake, one per cycle.
// Optional feature: define ENCODER_RR_EN for round-robin selection.
// Without it, the highest pending index always wins.
module encoder4_pend #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pend,
  output logic              busy
);

  logic              fire;
  logic              any_pend;
  logic              grant;
  logic [CODE_W-1:0] sel;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  pend_next;

  // The output slot can take a new code when empty or being drained.
  assign fire     = !out_valid || out_ready;
  // Only the registered pend is considered; this cycle's req waits a cycle.
  assign any_pend = |pend;
  assign grant    = fire && any_pend;
  assign busy     = any_pend || out_valid;

`ifdef ENCODER_RR_EN
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] rr_idx;

  // Round-robin pick: first pending index at or above ptr, wrapping to 0.
  // Scanning from the far end down lets the nearest hit overwrite the rest.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sel    = '0;
    rr_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      // CODE_W-bit addition wraps N_REQ-1 -> 0 since N_REQ is a power of two.
      rr_idx = ptr + CODE_W'(k);
      if (pend[rr_idx]) sel = rr_idx;
    end
  end

  // Pointer advances past the granted line, only when a grant happens.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (grant) ptr <= sel + CODE_W'(1);
  end
`else
  // Fixed-priority pick: highest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pend[i]) sel = CODE_W'(i);
    end
  end
`endif

  // One-hot clear of the granted line.
  always_comb begin
    clr = '0;
    if (grant) clr[sel] = 1'b1;
  end

  // Set wins over clear: a line re-requested while granted stays pending.
  assign pend_next = (pend & ~clr) | req;

  // Pending-request register; repeated requests merge into one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_next;
  end

  // Output slot: load a new code on fire, otherwise hold code and valid stable.
  // With nothing pending the slot empties but code keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code      <= '0;
    end else if (fire) begin
      out_valid <= any_pend;
      if (any_pend) code <= sel;
    end
  end

endmodule

// File: tb/tb_encoder4_pend.sv
// Testbench for encoder4_pend. Expected codes are queued as stimulus is
// driven and popped by a monitor whenever a code is accepted.
// Build with ENCODER_RR_EN defined to exercise round-robin expectations.
module tb_encoder4_pend;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] code;
  logic [3:0] pend;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  encoder4_pend #(.N_REQ(4), .CODE_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .pend      (pend),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a code is accepted at the next rising edge when valid and ready
  // are both high mid-cycle; compare it against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code %0d, none expected", code);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (code !== e) begin
          errors++;
          $display("FAIL sb_code: got %0d expected %0d", code, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the scoreboard to empty, then confirm the DUT is idle.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d codes still expected", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL %s_idle: valid=%b busy=%b pend=%b expected 0 0 0000",
               name, out_valid, busy, pend);
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_code;
`ifdef ENCODER_RR_EN
    exp_code = 2'd0;
`else
    exp_code = 2'd3;
`endif
    do_reset();
    @(negedge clk);
    checks++;
    if (pend !== 4'b0 || out_valid !== 1'b0 || code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: pend=%b valid=%b code=%0d busy=%b expected 0000 0 0 0",
               pend, out_valid, code, busy);
    end
    // Fill pend while the consumer stalls, then reset between edges.
    @(posedge clk);
    #1;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pend !== 4'b1111 || out_valid !== 1'b1 || code !== exp_code) begin
      errors++;
      $display("FAIL reset_prefill: pend=%b valid=%b code=%0d expected 1111 1 %0d",
               pend, out_valid, code, exp_code);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pend !== 4'b0 || out_valid !== 1'b0 || code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pend=%b valid=%b code=%0d busy=%b expected 0000 0 0 0",
               pend, out_valid, code, busy);
    end
    req = '0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req = 4'b0100;
    exp_q.push_back(2'd2);
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    checks++;
    if (pend !== 4'b0100 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: pend=%b valid=%b expected 0100 0", pend, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || code !== 2'd2) begin
      errors++;
      $display("FAIL single_t2: valid=%b code=%0d expected 1 2", out_valid, code);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pend !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_t3: valid=%b pend=%b busy=%b expected 0 0000 0",
               out_valid, pend, busy);
    end
    wait_drain("single");
  endtask

  task automatic test_multi_hot();
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req = 4'b1011;
`ifdef ENCODER_RR_EN
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
`else
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
`endif
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    // Three codes on consecutive cycles: no bubbles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL multi_b2b%0d: valid=%b expected 1", k, out_valid);
      end
    end
    wait_drain("multi");
  endtask

  task automatic test_stall();
    do_reset();
    @(posedge clk);
    #1;
    req = 4'b0001;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || code !== 2'd0 || pend !== 4'b0001) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b code=%0d pend=%b expected 1 0 0001",
                 k, out_valid, code, pend);
      end
      @(posedge clk);
    end
    #1;
    req       = '0;
    out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_collision();
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req = 4'b1000;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    repeat (2) @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    checks++;
    if (pend[3] !== 1'b1 || out_valid !== 1'b1 || code !== 2'd3) begin
      errors++;
      $display("FAIL collide_pend: pend=%b valid=%b code=%0d expected 1xxx 1 3",
               pend, out_valid, code);
    end
    wait_drain("collide");
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req = 4'b1111;
`ifdef ENCODER_RR_EN
    for (int k = 0; k < 11; k++) exp_q.push_back(2'(k % 4));
`else
    for (int k = 0; k < 8; k++) exp_q.push_back(2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
`endif
    repeat (8) @(posedge clk);
    #1;
    req = '0;
    wait_drain("b2b");
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_multi_hot();
    test_stall();
    test_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
